// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round count, 128-bit state type, FSM states and
// the GF(2^8) doubling helper used by MixColumns.
package aes_pkg;

  localparam int NR = 10;

  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_FINAL
  } fsm_e;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/mixColumnsE.sv
// Combinational MixColumns over four 32-bit columns; byte 0 of a column is its MSB.
module mixColumnsE
  import aes_pkg::*;
(
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;

    assign a0 = data_i[127-32*c -: 8];
    assign a1 = data_i[119-32*c -: 8];
    assign a2 = data_i[111-32*c -: 8];
    assign a3 = data_i[103-32*c -: 8];

    // 3*b is expressed as xtime(b) ^ b.
    assign data_o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign data_o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign data_o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign data_o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

endmodule

// File: rtl/subBytesE.sv
// SubBytes for a full 128-bit AES state: sixteen parallel forward S-box lookups.
module subBytesE (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  for (genvar n = 0; n < 16; n++) begin : g_sbox
    assign data_o[127-8*n -: 8] = SBOX[data_i[127-8*n -: 8]];
  end

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128 encryption core: one round per clock, round keys fetched
// from an external key store through key_idx.
module aes_cipher_core #(
  parameter int NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] round_key,
  output logic [3:0]   key_idx,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext
);

  aes_pkg::fsm_e   fsm_q, fsm_d;
  aes_pkg::state_t state_q, state_d;
  aes_pkg::state_t ct_q, ct_d;
  aes_pkg::state_t sub_bytes, shift_rows, mix_cols;
  logic [3:0]      round_q, round_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  subBytesE u_sub_bytes (
    .data_i (state_q),
    .data_o (sub_bytes)
  );

  // Row r of the state (bytes r, r+4, r+8, r+12) rotates left by r positions.
  for (genvar n = 0; n < 16; n++) begin : g_shift_rows
    localparam int SRC = (n % 4) + 4 * (((n / 4) + (n % 4)) % 4);
    assign shift_rows[127-8*n -: 8] = sub_bytes[127-8*SRC -: 8];
  end

  mixColumnsE u_mix_columns (
    .data_i (shift_rows),
    .data_o (mix_cols)
  );

  always_comb begin
    // NOTE: every output of this block gets a default before the case so no path leaves one unassigned and infers a latch.
    fsm_d   = fsm_q;
    state_d = state_q;
    ct_d    = ct_q;
    round_d = round_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (fsm_q)
      aes_pkg::ST_IDLE: begin
        if (start) begin
          state_d = plaintext ^ round_key;
          round_d = 4'd1;
          busy_d  = 1'b1;
          fsm_d   = aes_pkg::ST_ROUND;
        end
      end
      aes_pkg::ST_ROUND: begin
        state_d = mix_cols ^ round_key;
        round_d = round_q + 4'd1;
        if (round_q == 4'(NR - 1)) fsm_d = aes_pkg::ST_FINAL;
      end
      aes_pkg::ST_FINAL: begin
        ct_d    = shift_rows ^ round_key;
        round_d = 4'd0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        fsm_d   = aes_pkg::ST_IDLE;
      end
      default: fsm_d = aes_pkg::ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      fsm_q   <= aes_pkg::ST_IDLE;
      state_q <= '0;
      ct_q    <= '0;
      round_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      ct_q    <= ct_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign key_idx    = (fsm_q == aes_pkg::ST_IDLE) ? 4'd0 : round_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ciphertext = ct_q;

endmodule
